// File: rtl/ifu_fetch_buffer_if.sv
// Interface bundle for the fetch stage: redirect input, instruction ROM port and decode handshake.
// The master side is the fetch buffer itself; the slave side is the ROM/decode/redirect environment.
interface ifu_fetch_buffer_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        irom_req;
   logic [31:0] irom_addr;
   logic [31:0] irom_rdata;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic [25:0] id_imm_field;

   modport master (
      input  redirect_valid,
      input  redirect_pc,
      input  irom_rdata,
      input  id_ready,
      output irom_req,
      output irom_addr,
      output id_valid,
      output id_pc,
      output id_inst,
      output id_imm_field
   );

   modport slave (
      output redirect_valid,
      output redirect_pc,
      output irom_rdata,
      output id_ready,
      input  irom_req,
      input  irom_addr,
      input  id_valid,
      input  id_pc,
      input  id_inst,
      input  id_imm_field
   );
endinterface

// File: rtl/ifu_fetch_buffer.sv
// Instruction-fetch stage: sequential PC, 1-cycle-latency ROM requests gated by FIFO credit,
// and a small {pc, inst} FIFO feeding decode over valid/ready. Redirects flush everything.
module ifu_fetch_buffer #(
   parameter logic [31:0] RESET_PC   = 32'h1C00_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   ifu_fetch_buffer_if.master  bus
);

   localparam int              PW       = $clog2(FIFO_DEPTH);
   localparam int              CW       = $clog2(FIFO_DEPTH + 1);
   localparam logic [PW-1:0]   LAST_PTR = PW'(FIFO_DEPTH - 1);
   localparam logic [CW:0]     DEPTH_W  = (CW + 1)'(FIFO_DEPTH);

   logic [31:0]   pc_reg;
   logic [31:0]   pc_q_reg;
   logic          inflight_reg;
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;
   logic [CW:0]   occupancy;
   logic          req;
   logic          pop;
   logic          push;
   logic          kill;
   logic          unused_redirect_bits;

   logic [31:0]   slot_pc   [FIFO_DEPTH];
   logic [31:0]   slot_inst [FIFO_DEPTH];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign unused_redirect_bits = ^bus.redirect_pc[1:0];

   assign pop = (count_reg != '0) && bus.id_ready;

   // Credit counts entries held, the response still in flight, and the slot freed by this pop.
   assign occupancy = {1'b0, count_reg}
                    + {{CW{1'b0}}, inflight_reg}
                    - {{CW{1'b0}}, pop};

   assign req = rst_n && !bus.redirect_valid && (occupancy < DEPTH_W);

   // With a fixed 1-cycle ROM, the killed response is the one arriving in the redirect cycle itself.
   assign kill = bus.redirect_valid && inflight_reg;
   assign push = inflight_reg && !kill;

   assign count_next = count_reg + CW'(push) - CW'(pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg       <= RESET_PC;
         pc_q_reg     <= '0;
         inflight_reg <= 1'b0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
      end else begin
         inflight_reg <= req;
         if (req) begin
            pc_q_reg <= pc_reg;
         end
         if (bus.redirect_valid) begin
            pc_reg     <= {bus.redirect_pc[31:2], 2'b00};
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
         end else begin
            if (req) begin
               pc_reg <= pc_reg + 32'd4;
            end
            if (push) begin
               wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
               rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_next;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
         logic [31:0] entry_pc_reg;
         logic [31:0] entry_inst_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               entry_pc_reg   <= '0;
               entry_inst_reg <= '0;
            end else if (push && (wr_ptr_reg == PW'(gi))) begin
               entry_pc_reg   <= pc_q_reg;
               entry_inst_reg <= bus.irom_rdata;
            end
         end

         assign slot_pc[gi]   = entry_pc_reg;
         assign slot_inst[gi] = entry_inst_reg;
      end
   endgenerate

   assign bus.irom_req     = req;
   assign bus.irom_addr    = pc_reg;
   assign bus.id_valid     = (count_reg != '0);
   assign bus.id_pc        = slot_pc[rd_ptr_reg];
   assign bus.id_inst      = slot_inst[rd_ptr_reg];
   assign bus.id_imm_field = slot_inst[rd_ptr_reg][25:0];

endmodule
